// File: rtl/uart_frame_assembler.sv
// Packs received UART characters into fixed-size frames, offers each frame over valid/ready,
// discards stalled partial frames after an idle timeout and counts bytes dropped while holding.
module uart_frame_assembler #(
  parameter int unsigned DBITS          = 8,
  parameter int unsigned FRAME_BYTES    = 18,
  parameter int unsigned TIMEOUT_CYCLES = 1_033_400
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DBITS-1:0]                   rx_byte,
  input  logic                               rx_byte_valid,
  output logic [FRAME_BYTES*DBITS-1:0]       frame,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
  output logic                               timeout_pulse,
  output logic                               overrun_pulse,
  output logic [7:0]                         drop_count
);

  localparam int unsigned CW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TimerLast = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LastSlot  = CW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      frame         <= '0;
      frame_valid   <= 1'b0;
      byte_count    <= '0;
      timeout_pulse <= 1'b0;
      overrun_pulse <= 1'b0;
      drop_count    <= '0;
      timer         <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      overrun_pulse <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rx_byte_valid) begin
            frame[DBITS-1:0] <= rx_byte;
            byte_count       <= CW'(1);
            timer            <= '0;
            if (FRAME_BYTES == 1) begin
              state       <= StHold;
              frame_valid <= 1'b1;
            end else begin
              state <= StCollect;
            end
          end
        end

        StCollect: begin
          if (rx_byte_valid) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
              if (byte_count == CW'(i)) frame[i*DBITS +: DBITS] <= rx_byte;
            end
            byte_count <= byte_count + CW'(1);
            timer      <= '0;
            if (byte_count == LastSlot) begin
              state       <= StHold;
              frame_valid <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            // This idle clock is the TIMEOUT_CYCLES-th in a row: drop the partial frame.
            if (timer == TimerLast) begin
              byte_count    <= '0;
              timer         <= '0;
              timeout_pulse <= 1'b1;
              state         <= StIdle;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end

        StHold: begin
          if (frame_ready) begin
            byte_count <= '0;
            timer      <= '0;
            if (rx_byte_valid) begin
              frame[DBITS-1:0] <= rx_byte;
              byte_count       <= CW'(1);
              if (FRAME_BYTES == 1) begin
                state <= StHold;
              end else begin
                state       <= StCollect;
                frame_valid <= 1'b0;
              end
            end else begin
              state       <= StIdle;
              frame_valid <= 1'b0;
            end
          end else if (rx_byte_valid) begin
            overrun_pulse <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomized and directed bench for uart_frame_assembler with a queue-free behavioural model
// (FRAME_BYTES=4, TIMEOUT_CYCLES=100) plus a second instance with the timeout disabled.
module tb_uart_frame_assembler;

  localparam int FB = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_byte_valid = 1'b0;
  logic        frame_ready = 1'b0;
  logic [31:0] frame;
  logic        frame_valid;
  logic [2:0]  byte_count;
  logic        timeout_pulse, overrun_pulse;
  logic [7:0]  drop_count;

  logic [31:0] nt_frame;
  logic        nt_frame_valid;
  logic [2:0]  nt_byte_count;
  logic        nt_timeout_pulse, nt_overrun_pulse;
  logic [7:0]  nt_drop_count;

  uart_frame_assembler #(.DBITS(8), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .byte_count(byte_count), .timeout_pulse(timeout_pulse), .overrun_pulse(overrun_pulse),
    .drop_count(drop_count)
  );

  uart_frame_assembler #(.DBITS(8), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame(nt_frame), .frame_valid(nt_frame_valid), .frame_ready(frame_ready),
    .byte_count(nt_byte_count), .timeout_pulse(nt_timeout_pulse),
    .overrun_pulse(nt_overrun_pulse), .drop_count(nt_drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int nt_pulses = 0;

  // Behavioural model: bytes received so far, whether a frame is on offer, idle clocks, drops.
  logic [7:0] m_bytes [FB];
  int         m_cnt = 0, m_idle = 0, m_drops = 0;
  bit         m_hold = 0, m_tp = 0, m_op = 0;

  function automatic logic [31:0] m_frame();
    return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] b, input bit rdy);
    m_tp = 0;
    m_op = 0;
    if (r) begin
      m_cnt = 0; m_idle = 0; m_drops = 0; m_hold = 0;
      for (int i = 0; i < FB; i++) m_bytes[i] = '0;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        m_cnt  = 0;
        m_idle = 0;
        if (v) begin
          m_bytes[0] = b;
          m_cnt      = 1;
        end
      end else if (v) begin
        m_op = 1;
        if (m_drops < 255) m_drops++;
      end
    end else if (v) begin
      m_bytes[m_cnt] = b;
      m_cnt++;
      m_idle = 0;
      if (m_cnt == FB) m_hold = 1;
    end else if (m_cnt > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_tp   = 1;
        m_cnt  = 0;
        m_idle = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] b, input bit rdy);
    rst = r; rx_byte_valid = v; rx_byte = b; frame_ready = rdy;
    @(posedge clk);
    model_step(r, v, b, rdy);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("frame_valid", 64'(frame_valid), 64'(m_hold));
      chk("byte_count", 64'(byte_count), 64'(m_cnt));
      chk("timeout_pulse", 64'(timeout_pulse), 64'(m_tp));
      chk("overrun_pulse", 64'(overrun_pulse), 64'(m_op));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      if (m_hold) chk("frame", 64'(frame), 64'(m_frame()));
    end
    if (nt_timeout_pulse) nt_pulses++;
  end

  initial begin
    cyc(1, 0, 8'h00, 0);
    cmp_en = 1'b1;
    chk("reset_frame", 64'(frame), 64'h0);
    chk("reset_valid", 64'(frame_valid), 64'h0);

    // 1: frame held while not ready, then released
    cyc(0, 1, 8'h11, 0); cyc(0, 1, 8'h22, 0); cyc(0, 1, 8'h33, 0);
    chk("t1_not_yet_valid", 64'(frame_valid), 64'h0);
    cyc(0, 1, 8'h44, 0);
    chk("t1_valid", 64'(frame_valid), 64'h1);
    chk("t1_frame", 64'(frame), 64'h44332211);
    chk("t1_model_frame", 64'(m_frame()), 64'h44332211);
    repeat (50) cyc(0, 0, 8'h00, 0);
    chk("t1_still_held", 64'(frame), 64'h44332211);
    cyc(0, 0, 8'h00, 1);
    chk("t1_released", 64'(frame_valid), 64'h0);

    // 2: always ready, back-to-back bytes
    cyc(1, 0, 8'h00, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'(i), 1);
      if (i == 4) chk("t2_frame_a", 64'(frame), 64'h04030201);
      if (i == 5) chk("t2_valid_one_clk", 64'(frame_valid), 64'h0);
      if (i == 5) chk("t2_next_count", 64'(byte_count), 64'h1);
      if (i == 8) chk("t2_frame_b", 64'(frame), 64'h08070605);
    end
    cyc(0, 0, 8'h00, 1);
    chk("t2_drop_valid", 64'(frame_valid), 64'h0);

    // 3: timeout after 100 idle clocks
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hAA, 0); cyc(0, 1, 8'hBB, 0);
    repeat (99) cyc(0, 0, 8'h00, 0);
    chk("t3_no_early_timeout", 64'(timeout_pulse), 64'h0);
    chk("t3_count_before", 64'(byte_count), 64'h2);
    cyc(0, 0, 8'h00, 0);
    chk("t3_timeout", 64'(timeout_pulse), 64'h1);
    chk("t3_count_after", 64'(byte_count), 64'h0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i), 0);
    chk("t3_frame", 64'(frame), 64'h04030201);

    // 4: overrun while holding
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hA1 + 8'(i), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'hE0, 0);
      chk("t4_overrun", 64'(overrun_pulse), 64'h1);
    end
    chk("t4_drops", 64'(drop_count), 64'h3);
    chk("t4_frame_kept", 64'(frame), 64'hA4A3A2A1);
    cyc(0, 1, 8'h55, 1);
    chk("t4_count", 64'(byte_count), 64'h1);
    chk("t4_slot0", 64'(frame[7:0]), 64'h55);
    chk("t4_valid_off", 64'(frame_valid), 64'h0);

    // 5: reset mid-frame and while holding
    cyc(0, 1, 8'h66, 0);
    cyc(1, 0, 8'h00, 0);
    chk("t5_rst_count", 64'(byte_count), 64'h0);
    chk("t5_rst_frame", 64'(frame), 64'h0);
    chk("t5_rst_drops", 64'(drop_count), 64'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h70 + 8'(i), 0);
    cyc(1, 1, 8'h99, 0);
    chk("t5_rst_hold_valid", 64'(frame_valid), 64'h0);
    chk("t5_rst_hold_frame", 64'(frame), 64'h0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i), 0);
    chk("t5_clean_frame", 64'(frame), 64'h04030201);

    // 6: drop_count saturation and disabled timeout
    cyc(1, 0, 8'h00, 0);
    nt_pulses = 0;
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h10 + 8'(i), 0);
    repeat (300) cyc(0, 1, 8'($urandom), 0);
    chk("t6_saturated", 64'(drop_count), 64'd255);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'hC1, 0); cyc(0, 1, 8'hC2, 0);
    repeat (10000) cyc(0, 0, 8'h00, 0);
    chk("t6_nt_no_timeout", 64'(nt_pulses), 64'h0);
    chk("t6_nt_count", 64'(nt_byte_count), 64'h2);
    cyc(0, 1, 8'hC3, 0); cyc(0, 1, 8'hC4, 0);
    chk("t6_nt_valid", 64'(nt_frame_valid), 64'h1);
    chk("t6_nt_frame", 64'(nt_frame), 64'hC4C3C2C1);

    // Random traffic against the model
    cyc(1, 0, 8'h00, 0);
    repeat (60) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(90, 110)) cyc(0, 0, 8'h00, ($urandom_range(0, 3) == 0));
      end else begin
        repeat (60) cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
                        8'($urandom), ($urandom_range(0, 2) == 0));
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
